frame_scheduler: RTL
====================

// Module: frame_scheduler
// PURPOSE
//  Sequences the recognition Core: collects per-timestep glove samples into a sliding window
//  of WIN timesteps x N_CH channels and issues one frame per STRIDE new samples.
//  Each frame is issued via a 1-cycle start pulse with stable data. It then waits for Core
//  completion (step done / word finished) or a watchdog timeout before issuing the next frame.
//  After a word finishes, it flushes the window so the next word starts clean.
// PARAMETERS
//  N_CH     8     channels per timestep (16-bit signed each)
//  WIN      5     timesteps per frame; frame = N_CH*WIN = 40 words
//  STRIDE   2     new samples required between issues; legal range 1..WIN
//  TIMEOUT  1024  max WAIT cycles before forced release; >= 2
// PORTS
//  i_clk            in   1            clock, rising edge
//  i_rst_n          in   1            asynchronous reset, active-low
//  i_valid          in   1            i_sample valid this cycle; always accepted (no backpressure)
//  i_sample         in   N_CH*16      one timestep; channel c at [16c+15:16c], signed
//  o_start          out  1            1-cycle pulse: o_data holds a new frame (drives Core i_next)
//  o_data           out  16 x N_CH*WIN  signed frame; word [c + N_CH*t], t=0 oldest
//  i_core_next      in   1            Core pulse: frame consumed, step done
//  i_core_finished  in   1            Core pulse: word complete
//  o_busy           out  1            1 while in S_WAIT
//  o_word_done      out  1            registered 1-cycle copy of i_core_finished
//  o_timeout        out  1            1-cycle pulse when watchdog releases S_WAIT
//  o_drop_count     out  16           samples lost unissued; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, i_rst_n=0): all outputs 0; window, fill, pending, wdog = 0; state S_FILL.
//  Window: each accepted sample shifts in as t=WIN-1 and discards t=0, in every state.
//   fill is incremented per accepted sample and saturates at WIN.
//   pending (samples since last issue) is incremented per accepted sample and saturates at WIN.
//  S_FILL: issue when registered fill==WIN && pending>=STRIDE:
//   o_data<=window (pre-shift value), o_start<=1, state<=S_WAIT, wdog<=0.
//   pending <= (i_valid ? 1 : 0).
//   Issue latency: o_start is seen 1 cycle after the edge accepting the completing sample.
//  S_WAIT: o_data frozen; wdog increments each cycle.
//   i_core_finished -> S_FLUSH; o_word_done<=1.
//   else i_core_next -> S_FILL.
//   else wdog==TIMEOUT-1 -> S_FILL; o_timeout<=1.
//   Priority: finished > next > timeout. Handshake beats timeout in the same cycle.
//   Drop: accepted sample while pending==WIN -> drop count +1.
//  S_FLUSH (1 cycle): fill, pending <= (i_valid ? 1 : 0); the sample in this cycle is the
//   first of the new word; state<=S_FILL.
//  i_core_next/i_core_finished outside S_WAIT: ignored, except finished still pulses
//   o_word_done.
//  o_start never asserts in consecutive cycles. o_data changes only in the o_start cycle.
//  Reset mid-WAIT: immediate return to reset values; the in-flight frame is abandoned
//   with no o_start.
//  Widths: counters clog2-sized; drop counter 16-bit saturating, no wrap.
// CONFIGURATION
//  FRAME_SCHED_DROP_CNT_EN defined:
//   o_drop_count is implemented as above.
//  FRAME_SCHED_DROP_CNT_EN undefined:
//   no counter register; o_drop_count tied to 16'h0000; all other behaviour identical.
// TESTING
//  T1 fill/issue:
//   reset, 5 valid samples (ch c, step t = 100t+c) -> o_start one cycle after 5th accept.
//   o_data[0]=0, o_data[39]=407, o_busy=1.
//  T2 stride:
//   after T1, pulse i_core_next, then 1 sample -> no o_start.
//   2nd sample -> o_start; o_data[0] = value of step 2.
//  T3 timeout:
//   issue frame, never handshake -> o_timeout pulse exactly 1024 cycles after o_start.
//   state returns S_FILL; next issue works.
//  T4 simultaneous:
//   i_core_next and wdog==1023 on the same cycle -> no o_timeout.
//   i_core_finished + i_core_next together -> o_word_done=1, window flushed.
//   5 new samples are needed for the next o_start.
//  T5 drop (macro on):
//   hold S_WAIT, send 8 samples -> o_drop_count=3.
//   Macro off: same stimulus -> 0.
//  T6 reset mid-WAIT:
//   drop i_rst_n during S_WAIT -> all outputs 0 asynchronously.
//   After release, 4 samples produce no o_start.

Source files
------------

// File: rtl/frame_scheduler.sv
// Sliding-window frame scheduler for the recognition Core: buffers WIN timesteps, issues a frame every STRIDE samples.
// Define FRAME_SCHED_DROP_CNT_EN to implement the saturating dropped-sample counter on o_drop_count.
module frame_scheduler #(
    parameter int N_CH    = 8,
    parameter int WIN     = 5,
    parameter int STRIDE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [N_CH*16-1:0]    i_sample,
    output logic                  o_start,
    output logic signed [15:0]    o_data [N_CH*WIN],
    input  logic                  i_core_next,
    input  logic                  i_core_finished,
    output logic                  o_busy,
    output logic                  o_word_done,
    output logic                  o_timeout,
    output logic [15:0]           o_drop_count
);

    localparam int NW = N_CH * WIN;
    localparam int FW = $clog2(WIN + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FILL_MAX = FW'(WIN);
    localparam logic [FW-1:0] STRIDE_V = FW'(STRIDE);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_FILL, S_WAIT, S_FLUSH} state_t;

    state_t             state;
    logic signed [15:0] window [NW];
    logic [FW-1:0]      fill;
    logic [FW-1:0]      pending;
    logic [WW-1:0]      wdog;
    logic [FW-1:0]      fill_inc;
    logic [FW-1:0]      pending_inc;
    logic [FW-1:0]      restart_cnt;

    assign fill_inc    = (fill == FILL_MAX) ? fill : fill + FW'(1);
    assign pending_inc = (pending == FILL_MAX) ? pending : pending + FW'(1);
    assign restart_cnt = {{(FW-1){1'b0}}, i_valid};

    // Newest timestep lands in the top N_CH words; the oldest falls off the bottom.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NW; i++) window[i] <= '0;
        end else if (i_valid) begin
            for (int i = 0; i < NW - N_CH; i++) window[i] <= window[i + N_CH];
            for (int c = 0; c < N_CH; c++) window[NW - N_CH + c] <= i_sample[16*c +: 16];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_FILL;
            fill        <= '0;
            pending     <= '0;
            wdog        <= '0;
            o_start     <= 1'b0;
            o_busy      <= 1'b0;
            o_word_done <= 1'b0;
            o_timeout   <= 1'b0;
            for (int i = 0; i < NW; i++) o_data[i] <= '0;
        end else begin
            o_start     <= 1'b0;
            o_timeout   <= 1'b0;
            o_word_done <= i_core_finished;
            if (i_valid) begin
                fill    <= fill_inc;
                pending <= pending_inc;
            end
            case (state)
                S_FILL: begin
                    if (fill == FILL_MAX && pending >= STRIDE_V) begin
                        o_data  <= window;
                        o_start <= 1'b1;
                        o_busy  <= 1'b1;
                        wdog    <= '0;
                        pending <= restart_cnt;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog <= wdog + WW'(1);
                    // A Core handshake always wins over a watchdog expiry in the same cycle.
                    if (i_core_finished) begin
                        o_busy <= 1'b0;
                        state  <= S_FLUSH;
                    end else if (i_core_next) begin
                        o_busy <= 1'b0;
                        state  <= S_FILL;
                    end else if (wdog == WDOG_MAX) begin
                        o_busy    <= 1'b0;
                        o_timeout <= 1'b1;
                        state     <= S_FILL;
                    end
                end
                S_FLUSH: begin
                    fill    <= restart_cnt;
                    pending <= restart_cnt;
                    state   <= S_FILL;
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifdef FRAME_SCHED_DROP_CNT_EN
    logic [15:0] drop_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_count <= '0;
        end else if (state == S_WAIT && i_valid && pending == FILL_MAX
                     && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign o_drop_count = drop_count;
`else
    assign o_drop_count = 16'h0000;
`endif

endmodule
